// File: rtl/cic_decim_mc_pkg.sv
// Shared sizing helpers and default parameters for the multi-channel CIC decimator.
package cic_decim_mc_pkg;

    localparam int NCH_DEF           = 4;
    localparam int DATAIN_WIDTH_DEF  = 16;
    localparam int DATAOUT_WIDTH_DEF = 16;
    localparam int N_DEF             = 5;
    localparam int M_DEF             = 2;
    localparam int MAXRATE_DEF       = 64;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Full-precision register width: input width plus worst-case growth at MAXRATE.
    function automatic int cic_width(input int din, input int n, input int m, input int maxrate);
        return din + n * clog2(m * maxrate);
    endfunction

endpackage

// File: rtl/cic_decim_mc_lane.sv
// One CIC channel: ripple integrators, strobe sampler, pipelined combs and round/saturate.
module cic_decim_mc_lane #(
    parameter int DATAIN_WIDTH  = 16,
    parameter int DATAOUT_WIDTH = 16,
    parameter int N             = 5,
    parameter int M             = 2,
    parameter int W             = 51
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     acc_i,
    input  logic [N+1:0]             strb_i,
    input  logic [DATAIN_WIDTH-1:0]  x_i,
    output logic [DATAOUT_WIDTH-1:0] y_o
);

    localparam int SH = W - DATAOUT_WIDTH;

    logic [W-1:0]             integ_q [N];
    logic [W-1:0]             integ_d [N];
    logic [W-1:0]             sampler_q, sampler_d;
    logic [W-1:0]             dly_q   [N][M];
    logic [W-1:0]             dly_d   [N][M];
    logic [W-1:0]             pipe_q  [N];
    logic [W-1:0]             pipe_d  [N];
    logic [W-1:0]             comb_in [N];
    logic [DATAOUT_WIDTH-1:0] out_q, out_d, rs;
    logic [W-1:0]             x_ext;

    assign x_ext = {{(W - DATAIN_WIDTH){x_i[DATAIN_WIDTH-1]}}, x_i};

    // Integrators ripple within one clock so int[N-1] already includes the accepted sample.
    always_comb begin
        logic [W-1:0] ripple;
        integ_d = integ_q;
        ripple  = integ_q[0] + x_ext;
        if (en_i && acc_i) begin
            integ_d[0] = ripple;
            for (int k = 1; k < N; k++) begin
                ripple     = integ_q[k] + ripple;
                integ_d[k] = ripple;
            end
        end
    end

    always_comb begin
        sampler_d = sampler_q;
        pipe_d    = pipe_q;
        dly_d     = dly_q;
        out_d     = out_q;
        comb_in[0] = sampler_q;
        for (int k = 1; k < N; k++) comb_in[k] = pipe_q[k-1];

        if (en_i && strb_i[0]) sampler_d = integ_q[N-1];
        for (int k = 0; k < N; k++) begin
            if (en_i && strb_i[k+1]) begin
                pipe_d[k]   = comb_in[k] - dly_q[k][M-1];
                dly_d[k][0] = comb_in[k];
                for (int m = 1; m < M; m++) dly_d[k][m] = dly_q[k][m-1];
            end
        end
        if (en_i && strb_i[N+1]) out_d = rs;
    end

    if (SH > 0) begin : g_round
        logic [W:0]             rnd;
        logic [DATAOUT_WIDTH:0] top;
        logic                   unused_lsb;

        // Half-up rounding; only a positive result can overflow, so clamp to +max.
        always_comb begin
            rnd = {pipe_q[N-1][W-1], pipe_q[N-1]} + ({{W{1'b0}}, 1'b1} << (SH - 1));
            top = rnd[W:SH];
            if (top[DATAOUT_WIDTH] != top[DATAOUT_WIDTH-1]) begin
                rs = {1'b0, {(DATAOUT_WIDTH - 1){1'b1}}};
            end else begin
                rs = top[DATAOUT_WIDTH-1:0];
            end
        end
        assign unused_lsb = ^rnd[SH-1:0];
    end else begin : g_trunc
        assign rs = pipe_q[N-1][W-1 -: DATAOUT_WIDTH];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: every pipeline register array is cleared so a reset drops in-flight frames.
            for (int k = 0; k < N; k++) begin
                integ_q[k] <= '0;
                pipe_q[k]  <= '0;
                for (int m = 0; m < M; m++) dly_q[k][m] <= '0;
            end
            sampler_q <= '0;
            out_q     <= '0;
        end else begin
            integ_q   <= integ_d;
            sampler_q <= sampler_d;
            dly_q     <= dly_d;
            pipe_q    <= pipe_d;
            out_q     <= out_d;
        end
    end

    assign y_o = out_q;

endmodule

// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator: shared phase counter, rate sanitiser and strobe pipeline.
module cic_decim_mc
    import cic_decim_mc_pkg::*;
#(
    parameter int NCH           = NCH_DEF,
    parameter int DATAIN_WIDTH  = DATAIN_WIDTH_DEF,
    parameter int DATAOUT_WIDTH = DATAOUT_WIDTH_DEF,
    parameter int N             = N_DEF,
    parameter int M             = M_DEF,
    parameter int MAXRATE       = MAXRATE_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic [NCH*DATAIN_WIDTH-1:0]   data_i,
    input  logic                          valid_i,
    input  logic [clog2(MAXRATE+1)-1:0]   rate_i,
    input  logic                          sync_i,
    output logic [NCH*DATAOUT_WIDTH-1:0]  data_o,
    output logic                          valid_o,
    output logic                          rate_err_o
);

    localparam int RW = clog2(MAXRATE + 1);
    localparam int W  = cic_width(DATAIN_WIDTH, N, M, MAXRATE);
    localparam logic [RW-1:0] MAXRATE_R = RW'(MAXRATE);

    logic [RW-1:0] rate_q, rate_d, cnt_q, cnt_d, san_rate;
    logic          err_q, err_d, san_err;
    logic          accept, strobe;
    logic [N+1:0]  strb_q, strb_d;
    logic          valid_q, valid_d;

    assign san_err  = (rate_i == '0) || (rate_i > MAXRATE_R);
    assign san_rate = san_err ? MAXRATE_R : rate_i;
    assign accept   = en_i & valid_i;

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        rate_d = rate_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        strobe = 1'b0;
        // A sync starts a fresh frame and overrides any wrap in the same cycle.
        if (en_i && sync_i) begin
            rate_d = san_rate;
            err_d  = san_err;
            if (accept) begin
                if (san_rate == RW'(1)) begin
                    strobe = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d  = RW'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end else if (accept) begin
            if (cnt_q == rate_q - 1'b1) begin
                strobe = 1'b1;
                cnt_d  = '0;
                rate_d = san_rate;
                err_d  = san_err;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        strb_d  = en_i ? {strb_q[N:0], strobe} : strb_q;
        valid_d = en_i & strb_q[N+1];
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
        if (rst_i) begin
            rate_q  <= san_rate;
            err_q   <= san_err;
            cnt_q   <= '0;
            strb_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            rate_q  <= rate_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            strb_q  <= strb_d;
            valid_q <= valid_d;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        cic_decim_mc_lane #(
            .DATAIN_WIDTH  (DATAIN_WIDTH),
            .DATAOUT_WIDTH (DATAOUT_WIDTH),
            .N             (N),
            .M             (M),
            .W             (W)
        ) u_lane (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .en_i   (en_i),
            .acc_i  (accept),
            .strb_i (strb_q),
            .x_i    (data_i[c*DATAIN_WIDTH +: DATAIN_WIDTH]),
            .y_o    (data_o[c*DATAOUT_WIDTH +: DATAOUT_WIDTH])
        );
    end

    assign valid_o    = valid_q;
    assign rate_err_o = err_q;

endmodule

// File: tb/tb_cic_decim_mc.sv
// Scoreboard bench: a closed-form CIC model (binomial sums) predicts every decimated output.
module tb_cic_decim_mc;
    import cic_decim_mc_pkg::*;

    localparam int NCH     = 4;
    localparam int DIW     = 16;
    localparam int DOW     = 16;
    localparam int N       = 5;
    localparam int M       = 2;
    localparam int MAXRATE = 64;
    localparam int RW      = clog2(MAXRATE + 1);
    localparam int W       = cic_width(DIW, N, M, MAXRATE);
    localparam int SH      = W - DOW;

    logic                 clk = 1'b0;
    logic                 rst, en, valid, sync;
    logic [NCH*DIW-1:0]   data_i;
    logic [RW-1:0]        rate;
    logic [NCH*DOW-1:0]   data_o;
    logic                 valid_o, rate_err_o;

    cic_decim_mc #(
        .NCH(NCH), .DATAIN_WIDTH(DIW), .DATAOUT_WIDTH(DOW), .N(N), .M(M), .MAXRATE(MAXRATE)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .data_i     (data_i),
        .valid_i    (valid),
        .rate_i     (rate),
        .sync_i     (sync),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .rate_err_o (rate_err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [63:0] data;
        int          c0;
    } exp_t;

    exp_t exp_q[$];
    int   en_cyc = 0;
    logic [63:0] last_data = '0;

    always @(posedge clk) if (en === 1'b1) en_cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("data", 64'(data_o), e.data);
                check("latency", 64'(en_cyc - e.c0), 64'(N + 2));
                last_data = 64'(data_o);
            end
        end
    end

    // Reference model: per-lane input history, strobe snapshots and frame bookkeeping.
    longint hist [NCH][$];
    longint snaps[NCH][$];
    int     m_cnt, m_rate, cur_rate;
    bit     m_err;
    logic signed [DIW-1:0] x_cur [NCH];

    function automatic longint binom(input int n, input int r);
        longint c = 1;
        for (int j = 0; j < r; j++) c = c * (n - j) / (j + 1);
        return c;
    endfunction

    // N-fold running sum of the inputs up to the newest sample, in closed form.
    function automatic longint nth_cumsum(input int l);
        int     k = hist[l].size() - 1;
        longint s = 0;
        for (int i = 0; i <= k; i++) s += binom(k - i + N - 1, N - 1) * hist[l][i];
        return s;
    endfunction

    // N-th order difference (lag M) over strobe snapshots, then wrap to W, round, saturate.
    function automatic logic [DOW-1:0] lane_out(input int l);
        int     j = snaps[l].size() - 1;
        longint y = 0;
        for (int i = 0; i <= N; i++) begin
            if (j - i * M >= 0) begin
                if (i % 2 == 1) y -= binom(N, i) * snaps[l][j - i * M];
                else            y += binom(N, i) * snaps[l][j - i * M];
            end
        end
        y = (y <<< (64 - W)) >>> (64 - W);
        y = (y + (longint'(1) <<< (SH - 1))) >>> SH;
        if (y > longint'(2 ** (DOW - 1) - 1)) y = longint'(2 ** (DOW - 1) - 1);
        return y[DOW-1:0];
    endfunction

    function automatic int san(input int r);
        return (r == 0 || r > MAXRATE) ? MAXRATE : r;
    endfunction

    task automatic step(input bit r, input bit e, input bit v, input bit s, input int rt);
        bit   strobe = 1'b0;
        exp_t ex;
        rst   = r;
        en    = e;
        valid = v;
        sync  = s;
        rate  = rt[RW-1:0];
        for (int l = 0; l < NCH; l++) data_i[l*DIW +: DIW] = x_cur[l];

        if (r) begin
            m_rate = san(rt);
            m_err  = (rt == 0 || rt > MAXRATE);
            m_cnt  = 0;
            for (int l = 0; l < NCH; l++) begin
                hist[l].delete();
                snaps[l].delete();
            end
        end else if (e) begin
            if (v) for (int l = 0; l < NCH; l++) hist[l].push_back(longint'(x_cur[l]));
            if (s) begin
                m_rate = san(rt);
                m_err  = (rt == 0 || rt > MAXRATE);
                if (v) begin
                    strobe = (m_rate == 1);
                    m_cnt  = strobe ? 0 : 1;
                end else begin
                    m_cnt = 0;
                end
            end else if (v) begin
                if (m_cnt == m_rate - 1) begin
                    strobe = 1'b1;
                    m_cnt  = 0;
                    m_rate = san(rt);
                    m_err  = (rt == 0 || rt > MAXRATE);
                end else begin
                    m_cnt++;
                end
            end
        end

        if (strobe) begin
            ex.data = '0;
            for (int l = 0; l < NCH; l++) begin
                snaps[l].push_back(nth_cumsum(l));
                ex.data[l*DOW +: DOW] = lane_out(l);
            end
            ex.c0 = en_cyc + 1;
            exp_q.push_back(ex);
        end

        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            check("reset_valid", 64'(valid_o), 64'd0);
            check("reset_data", 64'(data_o), 64'd0);
        end
        check("rate_err", 64'(rate_err_o), 64'(m_err));
    endtask

    task automatic set_dc(input int val);
        for (int l = 0; l < NCH; l++) x_cur[l] = DIW'(val);
    endtask

    task automatic set_rand();
        for (int l = 0; l < NCH; l++) x_cur[l] = DIW'($urandom);
    endtask

    task automatic accepts(input int n, input int rt);
        repeat (n) step(1'b0, 1'b1, 1'b1, 1'b0, rt);
    endtask

    task automatic accepts_rand(input int n, input int rt);
        repeat (n) begin
            set_rand();
            step(1'b0, 1'b1, 1'b1, 1'b0, rt);
        end
    endtask

    task automatic idle(input int n, input int rt);
        repeat (n) step(1'b0, 1'b1, 1'b0, 1'b0, rt);
    endtask

    task automatic check_lanes(input string name, input logic [DOW-1:0] exp);
        logic [DOW-1:0] lane;
        for (int l = 0; l < NCH; l++) begin
            lane = last_data[l*DOW +: DOW];
            check(name, 64'(lane), 64'(exp));
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; valid = 1'b0; sync = 1'b0; rate = RW'(64); data_i = '0;
        m_cnt = 0; m_rate = 64; m_err = 1'b0; cur_rate = 64;
        set_dc(0);

        step(1'b1, 1'b0, 1'b0, 1'b0, 64);
        step(1'b1, 1'b0, 1'b0, 1'b0, 64);

        // DC at full rate, then a mid-frame rate change to 32.
        set_dc(1000);
        accepts(900, 64);
        idle(10, 64);
        check_lanes("dc_r64", 16'd1000);
        accepts(500, 32);
        idle(10, 32);
        check_lanes("dc_r32", 16'd31);

        // Latency at R=4, plain and with enable gaps.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4);
        accepts_rand(4, 4);
        idle(12, 4);
        set_rand();
        step(1'b0, 1'b1, 1'b1, 1'b0, 4);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4);
        for (int i = 0; i < 16; i++) step(1'b0, (i % 3) != 0, 1'b0, 1'b0, 4);
        idle(4, 4);

        // Sync with a coincident accept at cnt=17, then sync to R=1, then sync without accept.
        step(1'b1, 1'b0, 1'b0, 1'b0, 64);
        accepts_rand(17, 64);
        set_rand();
        step(1'b0, 1'b1, 1'b1, 1'b1, 64);
        accepts_rand(70, 64);
        idle(10, 64);
        set_rand();
        step(1'b0, 1'b1, 1'b1, 1'b1, 1);
        accepts_rand(20, 1);
        idle(10, 1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8);
        accepts_rand(20, 8);
        idle(10, 8);

        // Invalid rates fall back to MAXRATE; rate 1 picked up at a wrap.
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        accepts_rand(140, 0);
        set_rand();
        step(1'b0, 1'b1, 1'b1, 1'b1, 65);
        accepts_rand(140, 65);
        accepts_rand(80, 1);
        idle(10, 1);

        // Full scale both signs, then reset mid-frame.
        step(1'b1, 1'b0, 1'b0, 1'b0, 64);
        set_dc(32767);
        accepts(900, 64);
        idle(10, 64);
        check_lanes("full_pos", 16'h7fff);
        step(1'b1, 1'b0, 1'b0, 1'b0, 64);
        set_dc(-32768);
        accepts(900, 64);
        idle(10, 64);
        check_lanes("full_neg", 16'h8000);
        accepts_rand(30, 64);
        step(1'b1, 1'b1, 1'b1, 1'b0, 64);
        accepts_rand(200, 64);
        idle(10, 64);

        // Randomised traffic: gaps, syncs, rate changes, rare resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                case ($urandom_range(0, 9))
                    0:       cur_rate = 0;
                    1:       cur_rate = int'($urandom_range(65, 127));
                    2:       cur_rate = 1;
                    default: cur_rate = int'($urandom_range(2, 64));
                endcase
            end
            set_rand();
            step($urandom_range(0, 499) == 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 79) == 0, cur_rate);
        end
        idle(12, cur_rate);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
